// File: rtl/layer_desc_decoder.sv
// Layer-descriptor decoder: derives padded/output dims, tile sizes, GLB-fitting tile_n and
// channel tile counts through one shared iterative restoring divider, behind valid/ready.
module layer_desc_decoder #(
   parameter int GLB_BYTES = 65536,
   parameter int BYTES_I   = 1,
   parameter int BYTES_W   = 1,
   parameter int BYTES_P   = 4,
   parameter int DIM_W     = 8,
   parameter int CH_W      = 11,
   parameter int DIV_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              desc_valid_i,
   output logic              desc_ready_o,
   input  logic [1:0]        layer_type_i,
   input  logic [1:0]        kernel_i,
   input  logic [DIM_W-1:0]  in_R_i,
   input  logic [DIM_W-1:0]  in_C_i,
   input  logic [CH_W-1:0]   in_D_i,
   input  logic [CH_W-1:0]   out_K_i,
   input  logic [1:0]        stride_i,
   input  logic [1:0]        pad_T_i,
   input  logic [1:0]        pad_B_i,
   input  logic [1:0]        pad_L_i,
   input  logic [1:0]        pad_R_i,
   input  logic [3:0]        flags_i,
   output logic              cfg_valid_o,
   input  logic              cfg_ready_i,
   output logic [1:0]        layer_type_o,
   output logic [3:0]        flags_o,
   output logic [1:0]        kernel_o,
   output logic [DIM_W+1:0]  padded_R_o,
   output logic [DIM_W+1:0]  padded_C_o,
   output logic [DIM_W+1:0]  out_R_o,
   output logic [DIM_W+1:0]  out_C_o,
   output logic [6:0]        tile_D_o,
   output logic [6:0]        tile_K_o,
   output logic [DIV_W-1:0]  tile_n_o,
   output logic [CH_W-1:0]   num_tiles_D_o,
   output logic [CH_W-1:0]   num_tiles_K_o,
   output logic              err_o,
   output logic              busy_o
);

   // state  | meaning
   // IDLE   | waiting for a descriptor
   // SETUP  | dims, tile table, byte terms, error checks
   // DIV_R  | out_R = (padded_R - k) / stride + 1
   // DIV_C  | out_C = (padded_C - k) / stride + 1
   // DIV_N  | tile_n = ((GLB - T1 - T3) / T2) & ~3
   // DIV_TD | num_tiles_D = ceil(in_D / tile_D)
   // DIV_TK | num_tiles_K = ceil(out_K / tile_K)
   // DONE   | config presented until consumed
   typedef enum logic [2:0] {IDLE, SETUP, DIV_R, DIV_C, DIV_N, DIV_TD, DIV_TK, DONE} state_t;

   localparam int ODW   = DIM_W + 2;
   localparam int CNT_W = $clog2(DIV_W);
   localparam logic [DIV_W-1:0] GLB_W = DIV_W'(GLB_BYTES);
   localparam logic [DIV_W:0]   GLB_X = (DIV_W+1)'(GLB_BYTES);

   state_t state, state_nxt;

   logic [1:0]       lt_q, kern_q, stride_q, pad_t_q, pad_b_q, pad_l_q, pad_r_q;
   logic [DIM_W-1:0] in_r_q, in_c_q;
   logic [CH_W-1:0]  in_d_q, out_k_q;

   logic [1:0]       k_eff;
   logic [DIV_W-1:0] k_w, pr_w, pc_w, m_w, t1, t2, t3;
   logic [DIV_W:0]   fit_sum;
   logic [6:0]       td, tk, df, kf;
   logic             setup_err;

   logic [DIV_W-1:0] rem_q, quo_q, dvs_q, rem_nxt, quo_nxt, op_a, op_b;
   logic [DIV_W:0]   shifted;
   logic             ge, last, in_div, load;
   logic [CNT_W-1:0] cnt_q;

   assign desc_ready_o = (state == IDLE);
   assign busy_o       = (state != IDLE);

   always_comb begin
      k_eff = (lt_q == 2'd3) ? 2'd1 : kern_q;
      k_w   = DIV_W'(k_eff);
      pr_w  = DIV_W'(in_r_q) + DIV_W'(pad_t_q) + DIV_W'(pad_b_q);
      pc_w  = DIV_W'(in_c_q) + DIV_W'(pad_l_q) + DIV_W'(pad_r_q);
      case (lt_q)
         2'd1:    begin td = 7'd10; tk = 7'd10; df = 7'd1;  kf = 7'd10; end
         2'd2:    begin td = 7'd10; tk = 7'd10; df = 7'd10; kf = 7'd10; end
         default: begin td = 7'd32; tk = 7'd32; df = 7'd32; kf = 7'd32; end
      endcase
      m_w = (lt_q == 2'd0 || lt_q == 2'd3) ? DIV_W'(1) : DIV_W'(in_c_q) + DIV_W'(1);
      t1  = k_w * k_w * DIV_W'(df) * DIV_W'(kf) * DIV_W'(BYTES_W);
      t2  = DIV_W'(in_d_q) * DIV_W'(BYTES_I) + DIV_W'(out_k_q) * DIV_W'(BYTES_P);
      t3  = m_w * DIV_W'(2) * DIV_W'(in_d_q) * DIV_W'(BYTES_I);
      fit_sum   = {1'b0, t1} + {1'b0, t3};
      setup_err = (stride_q == 2'd0) || (lt_q != 2'd3 && kern_q == 2'd0) ||
                  (pr_w < k_w) || (pc_w < k_w) || (fit_sum >= GLB_X);
   end

   // Operands for the division that follows the current state.
   always_comb begin
      op_a = '0;
      op_b = DIV_W'(1);
      case (state)
         SETUP:  begin op_a = pr_w - k_w;        op_b = DIV_W'(stride_q); end
         DIV_R:  begin op_a = pc_w - k_w;        op_b = DIV_W'(stride_q); end
         DIV_C:  begin op_a = GLB_W - t1 - t3;   op_b = t2; end
         DIV_N:  begin op_a = DIV_W'(in_d_q) + DIV_W'(td) - DIV_W'(1);  op_b = DIV_W'(td); end
         DIV_TD: begin op_a = DIV_W'(out_k_q) + DIV_W'(tk) - DIV_W'(1); op_b = DIV_W'(tk); end
         default: ;
      endcase
   end

   always_comb begin
      shifted = {rem_q, quo_q[DIV_W-1]};
      ge      = (shifted >= {1'b0, dvs_q});
      rem_nxt = ge ? (shifted[DIV_W-1:0] - dvs_q) : shifted[DIV_W-1:0];
      quo_nxt = {quo_q[DIV_W-2:0], ge};
      last    = (cnt_q == '0);
      in_div  = (state == DIV_R) || (state == DIV_C) || (state == DIV_N) ||
                (state == DIV_TD) || (state == DIV_TK);
      load    = (state == SETUP && !setup_err) || (in_div && last && state != DIV_TK);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (desc_valid_i) state_nxt = SETUP;
         SETUP:   state_nxt = setup_err ? DONE : DIV_R;
         DIV_R:   if (last) state_nxt = DIV_C;
         DIV_C:   if (last) state_nxt = DIV_N;
         DIV_N:   if (last) state_nxt = DIV_TD;
         DIV_TD:  if (last) state_nxt = DIV_TK;
         DIV_TK:  if (last) state_nxt = DONE;
         DONE:    if (cfg_valid_o && cfg_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lt_q <= '0; kern_q <= '0; stride_q <= '0;
         pad_t_q <= '0; pad_b_q <= '0; pad_l_q <= '0; pad_r_q <= '0;
         in_r_q <= '0; in_c_q <= '0; in_d_q <= '0; out_k_q <= '0;
         rem_q <= '0; quo_q <= '0; dvs_q <= '0; cnt_q <= '0;
         cfg_valid_o <= 1'b0; layer_type_o <= '0; flags_o <= '0; kernel_o <= '0;
         padded_R_o <= '0; padded_C_o <= '0; out_R_o <= '0; out_C_o <= '0;
         tile_D_o <= '0; tile_K_o <= '0; tile_n_o <= '0;
         num_tiles_D_o <= '0; num_tiles_K_o <= '0; err_o <= 1'b0;
      end else begin
         if (state == IDLE && desc_valid_i) begin
            lt_q <= layer_type_i; kern_q <= kernel_i; stride_q <= stride_i;
            pad_t_q <= pad_T_i; pad_b_q <= pad_B_i; pad_l_q <= pad_L_i; pad_r_q <= pad_R_i;
            in_r_q <= in_R_i; in_c_q <= in_C_i; in_d_q <= in_D_i; out_k_q <= out_K_i;
            layer_type_o <= layer_type_i;
            flags_o      <= flags_i;
            kernel_o     <= (layer_type_i == 2'd3) ? 2'd1 : kernel_i;
            padded_R_o <= '0; padded_C_o <= '0; out_R_o <= '0; out_C_o <= '0;
            tile_D_o <= '0; tile_K_o <= '0; tile_n_o <= '0;
            num_tiles_D_o <= '0; num_tiles_K_o <= '0; err_o <= 1'b0;
         end
         if (state == SETUP) begin
            if (setup_err) err_o <= 1'b1;
            else begin
               padded_R_o <= pr_w[ODW-1:0];
               padded_C_o <= pc_w[ODW-1:0];
               tile_D_o   <= td;
               tile_K_o   <= tk;
            end
         end
         if (load) begin
            rem_q <= '0;
            quo_q <= op_a;
            dvs_q <= op_b;
            cnt_q <= CNT_W'(DIV_W - 1);
         end else if (in_div && !last) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
         end
         // Final quotient bit is taken straight from quo_nxt on the terminal count.
         if (in_div && last) begin
            case (state)
               DIV_R:  out_R_o <= quo_nxt[ODW-1:0] + ODW'(1);
               DIV_C:  out_C_o <= quo_nxt[ODW-1:0] + ODW'(1);
               DIV_N: begin
                  tile_n_o <= {quo_nxt[DIV_W-1:2], 2'b00};
                  if (quo_nxt[DIV_W-1:2] == '0) err_o <= 1'b1;
               end
               DIV_TD: num_tiles_D_o <= quo_nxt[CH_W-1:0];
               DIV_TK: num_tiles_K_o <= quo_nxt[CH_W-1:0];
               default: ;
            endcase
         end
         if (state == DONE && !cfg_valid_o)      cfg_valid_o <= 1'b1;
         else if (cfg_valid_o && cfg_ready_i)    cfg_valid_o <= 1'b0;
      end
   end

endmodule
